// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider and its benches.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEFAULT    = 27;
   localparam int unsigned DIV_DEFAULT_RST  = 50000000;
   localparam int unsigned SCAN_W_DEFAULT   = 2;
   localparam int unsigned SCAN_DIV_DEFAULT = 32768;
   localparam int unsigned PEND_RST         = 0;

endpackage

// File: rtl/clk_div_scan.sv
// Display-scan select counter: a prescaler bumps scan_ctl every SCAN_DIV enabled cycles.
// Only built when CLK_DIV_SCAN_EN is defined, since that is the only build that instantiates it.
`ifdef CLK_DIV_SCAN_EN
module clk_div_scan
   import clk_div_pkg::*;
#(
   parameter int unsigned SCAN_W   = SCAN_W_DEFAULT,
   parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [SCAN_W-1:0] scan_ctl
);

   localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PreW-1:0]   pre_q, pre_d;
   logic [SCAN_W-1:0] scan_q, scan_d;

   always_comb begin
      pre_d  = pre_q;
      scan_d = scan_q;
      if (en) begin
         if (pre_q == PreW'(SCAN_DIV - 1)) begin
            pre_d  = '0;
            scan_d = scan_q + 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         scan_q <= '0;
      end else begin
         pre_q  <= pre_d;
         scan_q <= scan_d;
      end
   end

   assign scan_ctl = scan_q;

endmodule
`endif

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with glitch-free divisor reload and tick output.
// Define CLK_DIV_SCAN_EN to add the display-scan counter; otherwise scan_ctl is tied to 0.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_RST,
   parameter int unsigned SCAN_W      = SCAN_W_DEFAULT,
   parameter int unsigned SCAN_DIV    = SCAN_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [CNT_W-1:0]  div_val,
   output logic              clk_out,
   output logic              tick,
   output logic [SCAN_W-1:0] scan_ctl
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             tc;

   assign tc = en && (cnt_q == div_q);

   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;
      // A load landing on terminal count bypasses the pending slot entirely.
      if (load && !tc) begin
         pend_d     = div_val;
         pend_vld_d = 1'b1;
      end
      if (tc) begin
         cnt_d      = '0;
         clk_out_d  = ~clk_out_q;
         tick_d     = ~clk_out_q;
         pend_vld_d = 1'b0;
         if (load) begin
            div_d = div_val;
         end else if (pend_vld_q) begin
            div_d = pend_q;
         end
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         div_q      <= CNT_W'(DIV_DEFAULT);
         pend_q     <= CNT_W'(PEND_RST);
         pend_vld_q <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;

`ifdef CLK_DIV_SCAN_EN
   clk_div_scan #(
      .SCAN_W   (SCAN_W),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .scan_ctl (scan_ctl)
   );
`else
   logic unused_scan_div;
   assign unused_scan_div = ^SCAN_DIV;
   assign scan_ctl        = '0;
`endif

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 27, meaning the divider counter and divisor width in bits.
REQ-002 SHALL have parameter DIV_DEFAULT, default 50000000, meaning the half-period terminal count loaded at reset.
REQ-003 SHALL have parameter SCAN_W, default 2, meaning the scan-control output width.
REQ-004 SHALL have parameter SCAN_DIV, default 32768, meaning the number of clk cycles per scan_ctl increment (>=1).
REQ-005 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  count enable; when low, all counters and outputs hold.
REQ-008 SHALL have port load  input  1  single-cycle request to capture div_val as the new terminal count.
REQ-009 SHALL have port div_val  input  CNT_W  new half-period terminal count, sampled when load=1.
REQ-010 SHALL have port clk_out  output  1  divided clock with 50% duty cycle, registered.
REQ-011 SHALL have port tick  output  1  one-cycle pulse, high in the cycle in which clk_out becomes 1.
REQ-012 SHALL have port scan_ctl  output  SCAN_W  free-running display-scan select, registered.

Function
REQ-013 SHALL keep an active divisor div_reg and a pending divisor pend_reg, both CNT_W bits wide, plus a pend_vld flag.
REQ-014 SHALL clear cnt to 0 and toggle clk_out when en=1 and cnt==div_reg (terminal count); otherwise, when en=1, cnt SHALL increment by 1.
REQ-015 SHALL give a half period of div_reg+1 cycles and a full period of 2*(div_reg+1) cycles; div_reg=0 gives clk/2.
REQ-016 SHALL assert tick only in the cycle in which clk_out transitions 0->1, and tick SHALL be 0 in every other cycle, including while en=0.
REQ-017 SHALL, on load=1, write div_val to pend_reg and set pend_vld; a later load before the pending value is applied SHALL overwrite pend_reg (last write wins).
REQ-018 SHALL copy pend_reg to div_reg and clear pend_vld at a terminal count, so that the new value governs the next half period; clk_out SHALL never produce a half period shorter than min(old, new)+1 cycles.
REQ-019 SHALL, when load and terminal count occur in the same cycle, apply div_val directly to div_reg for the next half period and leave pend_vld clear.
REQ-020 SHALL, when en=0, hold cnt, clk_out, div_reg and scan_ctl, while load SHALL still be accepted into pend_reg.
REQ-021 SHALL run a prescaler from 0 to SCAN_DIV-1 while en=1 and increment scan_ctl at wrap; scan_ctl SHALL wrap from 2^SCAN_W-1 to 0.
REQ-022 SHALL perform all arithmetic modulo 2^CNT_W; cnt SHALL never exceed div_reg.

Reset
REQ-023 SHALL, while rst_n=0, force cnt=0, clk_out=0, tick=0, scan_ctl=0, prescaler=0, div_reg=DIV_DEFAULT, pend_reg=0 and pend_vld=0, independent of clk.
REQ-024 SHALL, after rst_n deasserts mid-period, restart from a full low half period with any pending load discarded.

Configuration
REQ-025 SHALL, with the macro CLK_DIV_SCAN_EN defined, implement the scan prescaler and scan_ctl as specified in REQ-021.
REQ-026 SHALL, without CLK_DIV_SCAN_EN, keep the scan_ctl port, drive it constant 0, and contain no prescaler registers.

Structure
REQ-027 SHALL define SCAN_DIV_DEFAULT and the reset constants in the shared package clk_div_pkg, for use by clk_div_prog and the benches.
REQ-028 SHALL place the scan prescaler and scan_ctl counter in the sub-module clk_div_scan, which is instantiated only under CLK_DIV_SCAN_EN.

Verification
REQ-029 SHALL verify defaults: with DIV_DEFAULT=3 and en=1 after reset, clk_out toggles every 4 cycles (period 8) and tick is high once per 8 cycles, in the cycle clk_out rises.
REQ-030 SHALL verify a mid-period load: load div_val=1 at cnt=1 of a 4-cycle half period; the current half period completes at 4 cycles, then subsequent half periods are 2 cycles.
REQ-031 SHALL verify load coincident with terminal count: load div_val=0 at cnt==div_reg; the next half period is 1 cycle, giving clk_out at clk/2, and pend_vld stays 0.
REQ-032 SHALL verify enable hold: drop en for 5 cycles at cnt=2; cnt, clk_out and scan_ctl freeze, tick stays 0, and counting resumes from cnt=2.
REQ-033 SHALL verify scan wrap: with SCAN_DIV=4 and SCAN_W=2, scan_ctl steps 0,1,2,3,0 every 4 cycles; without CLK_DIV_SCAN_EN, scan_ctl stays 0.
REQ-034 SHALL verify reset mid-operation: assert rst_n=0 asynchronously with clk_out=1 and a load pending; all outputs go to 0 immediately, and after release the first half period uses DIV_DEFAULT.
